// File: rtl/fir_tdm_multichannel.sv
// Time-multiplexed multichannel FIR: one shared MAC walks the taps of the
// selected channel, then scales, rounds and saturates the result.
module fir_tdm_multichannel #(
   parameter int unsigned DATA_W   = 24,
   parameter int unsigned COEF_W   = 16,
   parameter int unsigned TAPS     = 16,
   parameter int unsigned CHANNELS = 3,
   parameter int unsigned SHIFT    = 14,
   localparam int unsigned CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
   localparam int unsigned TAP_W   = $clog2(TAPS)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [CH_W-1:0]          in_ch,
   input  logic signed [DATA_W-1:0] in_data,
   input  logic                     coef_we,
   input  logic [TAP_W-1:0]         coef_addr,
   input  logic signed [COEF_W-1:0] coef_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [CH_W-1:0]          out_ch,
   output logic signed [DATA_W-1:0] out_data
);

   localparam int unsigned PROD_W = DATA_W + COEF_W;
   localparam int unsigned ACC_W  = PROD_W + TAP_W;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MAC  = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;

   localparam logic signed [ACC_W-1:0] RND     = ACC_W'(1) << (SHIFT - 1);
   localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

   logic [1:0]               state;
   logic [1:0]               next_state;
   logic [TAP_W-1:0]         tap;
   logic [CH_W-1:0]          cur_ch;
   logic signed [ACC_W-1:0]  acc;
   logic signed [DATA_W-1:0] hist [CHANNELS][TAPS];
   logic signed [COEF_W-1:0] coef [TAPS];

   logic                     accept;
   logic                     ch_ok;
   logic                     last_tap;
   logic signed [PROD_W-1:0] prod;
   logic signed [ACC_W-1:0]  acc_sum;
   logic signed [ACC_W-1:0]  rounded;
   logic signed [ACC_W-1:0]  scaled;
   logic signed [DATA_W-1:0] sat_data;

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= next_state;
   end

   // Next state and handshake decode; in_ready is low throughout reset
   always_comb begin
      next_state = state;
      in_ready   = 1'b0;
      accept     = 1'b0;
      ch_ok      = 32'(in_ch) < CHANNELS;
      last_tap   = (tap == TAP_W'(TAPS - 1));
      case (state)
         ST_IDLE: begin
            in_ready = !reset;
            accept   = in_valid && !reset;
            if (accept && ch_ok) next_state = ST_MAC;
         end
         ST_MAC:  if (last_tap) next_state = ST_HOLD;
         ST_HOLD: if (out_valid && out_ready) next_state = ST_IDLE;
         default: next_state = ST_IDLE;
      endcase
   end

   // Shared MAC plus round/shift/saturate of the running sum
   always_comb begin
      prod    = PROD_W'(coef[tap]) * PROD_W'(hist[cur_ch][tap]);
      acc_sum = acc + ACC_W'(prod);
      rounded = acc_sum + RND;
      scaled  = rounded >>> SHIFT;
      if (scaled > SAT_MAX)      sat_data = SAT_MAX[DATA_W-1:0];
      else if (scaled < SAT_MIN) sat_data = SAT_MIN[DATA_W-1:0];
      else                       sat_data = scaled[DATA_W-1:0];
   end

   // Last tap lands straight in the output register, so the result is
   // presented in the (TAPS+1)th cycle after acceptance.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int c = 0; c < int'(CHANNELS); c++)
            for (int k = 0; k < int'(TAPS); k++)
               hist[c][k] <= '0;
         for (int k = 0; k < int'(TAPS); k++)
            coef[k] <= '0;
         coef[0]   <= COEF_W'(1 << SHIFT);
         acc       <= '0;
         tap       <= '0;
         cur_ch    <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
      end else begin
         if (coef_we) coef[coef_addr] <= coef_data;
         case (state)
            ST_IDLE: begin
               if (accept && ch_ok) begin
                  for (int k = 1; k < int'(TAPS); k++)
                     hist[in_ch][k] <= hist[in_ch][k-1];
                  hist[in_ch][0] <= in_data;
                  cur_ch         <= in_ch;
                  acc            <= '0;
                  tap            <= '0;
               end
            end
            ST_MAC: begin
               acc <= acc_sum;
               tap <= tap + TAP_W'(1);
               if (last_tap) begin
                  out_valid <= 1'b1;
                  out_data  <= sat_data;
                  out_ch    <= cur_ch;
               end
            end
            ST_HOLD: if (out_ready) out_valid <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fir_tdm_multichannel.sv
// Bench for fir_tdm_multichannel: vector table, directed corner sequences and
// randomized traffic checked against an arithmetic FIR model.
module tb_fir_tdm_multichannel;

   localparam int unsigned DATA_W   = 24;
   localparam int unsigned COEF_W   = 16;
   localparam int unsigned TAPS     = 16;
   localparam int unsigned CHANNELS = 3;
   localparam int unsigned SHIFT    = 14;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic [1:0]         in_ch = '0;
   logic signed [23:0] in_data = '0;
   logic               coef_we = 1'b0;
   logic [3:0]         coef_addr = '0;
   logic signed [15:0] coef_data = '0;
   logic               out_valid;
   logic               out_ready = 1'b1;
   logic [1:0]         out_ch;
   logic signed [23:0] out_data;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int acc_cyc = 0;

   int model_coef [TAPS];
   int model_hist [CHANNELS][TAPS];

   typedef struct {
      int coef0;
      int ch;
      int data;
      int exp;
   } vec_t;
   vec_t tbl [8];

   fir_tdm_multichannel #(
      .DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .CHANNELS(CHANNELS), .SHIFT(SHIFT)
   ) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .in_data(in_data),
      .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .out_data(out_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // y = sum coef*x, +half LSB, floor-shift, clamp to the sample range
   function automatic int fir_ref(input int c [TAPS], input int h [TAPS]);
      longint s = 0;
      for (int k = 0; k < int'(TAPS); k++) s += longint'(c[k]) * longint'(h[k]);
      s = (s + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
      if (s > 64'sd8388607) s = 64'sd8388607;
      if (s < -64'sd8388608) s = -64'sd8388608;
      return int'(s);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < int'(TAPS); k++) begin
         model_coef[k] = 0;
         for (int c = 0; c < int'(CHANNELS); c++) model_hist[c][k] = 0;
      end
      model_coef[0] = 1 << SHIFT;
   endtask

   task automatic model_push(input int ch, input int data);
      for (int k = int'(TAPS) - 1; k > 0; k--) model_hist[ch][k] = model_hist[ch][k-1];
      model_hist[ch][0] = data;
   endtask

   task automatic do_reset(input bit check_state);
      reset = 1'b1; in_valid = 1'b0; coef_we = 1'b0; out_ready = 1'b1;
      step();
      if (check_state) begin
         check("rst_in_ready", in_ready, 0);
         check("rst_out_valid", out_valid, 0);
         check("rst_out_data", out_data, 0);
         check("rst_out_ch", out_ch, 0);
      end
      step();
      reset = 1'b0;
      #1;
      if (check_state) check("rst_release_ready", in_ready, 1);
      model_reset();
   endtask

   task automatic write_coef(input int addr, input int val);
      coef_we = 1'b1; coef_addr = 4'(addr); coef_data = 16'(val);
      step();
      coef_we = 1'b0;
      model_coef[addr] = val;
   endtask

   task automatic wait_ready(output bit ok);
      int n = 0;
      while (!in_ready && n < 64) begin step(); n++; end
      ok = in_ready;
      if (!ok) check("in_ready_wait", 0, 1);
   endtask

   task automatic send(input int ch, input int data, input int hold, output int got);
      int n;
      int exp;
      int h [TAPS];
      bit ok;
      logic signed [23:0] d;
      logic [1:0] c;
      got = 0;
      wait_ready(ok);
      if (!ok) return;
      out_ready = (hold == 0);
      in_valid = 1'b1; in_ch = 2'(ch); in_data = 24'(data);
      step();
      acc_cyc = cyc;
      in_valid = 1'b0;
      model_push(ch, data);
      for (int k = 0; k < int'(TAPS); k++) h[k] = model_hist[ch][k];
      exp = fir_ref(model_coef, h);
      n = 0;
      while (!out_valid && n < int'(TAPS) + 8) begin step(); n++; end
      if (!out_valid) begin
         check("out_valid_timeout", 0, 1);
         out_ready = 1'b1;
         return;
      end
      check("latency", n, TAPS);
      got = int'(out_data);
      check("out_data", got, exp);
      check("out_ch", out_ch, ch);
      if (hold > 0) begin
         d = out_data; c = out_ch;
         for (int i = 0; i < hold; i++) begin
            step();
            check("hold_stable", (out_valid && !in_ready && out_data == d && out_ch == c) ? 1 : 0, 1);
         end
         out_ready = 1'b1;
         step();
         check("hold_release", out_valid, 0);
      end else begin
         step();
      end
   endtask

   task automatic send_invalid();
      bit ok;
      bit seen = 1'b0;
      wait_ready(ok);
      if (!ok) return;
      in_valid = 1'b1; in_ch = 2'd3; in_data = 24'(123);
      step();
      in_valid = 1'b0;
      check("invalid_idle", in_ready, 1);
      for (int i = 0; i < int'(TAPS) + 4; i++) begin
         if (out_valid) seen = 1'b1;
         step();
      end
      check("invalid_no_output", seen, 0);
   endtask

   // Coefficient writes while the MAC is walking the taps of one sample
   task automatic mac_write_test();
      int eff [TAPS];
      int h [TAPS];
      int exp;
      bit ok;
      wait_ready(ok);
      if (!ok) return;
      in_valid = 1'b1; in_ch = 2'd2; in_data = 24'(12345);
      step();
      in_valid = 1'b0;
      model_push(2, 12345);
      for (int k = 0; k < int'(TAPS); k++) begin
         eff[k] = model_coef[k];
         h[k] = model_hist[2][k];
      end
      eff[5] = 7000;  // written before tap 5 is read; tap 3 write coincides with its read
      exp = fir_ref(eff, h);
      for (int e = 1; e <= int'(TAPS); e++) begin
         coef_we   = (e == 4) || (e == 5);
         coef_addr = (e == 4) ? 4'd3 : 4'd5;
         coef_data = (e == 4) ? -16'sd5000 : 16'sd7000;
         step();
      end
      coef_we = 1'b0;
      model_coef[3] = -5000;
      model_coef[5] = 7000;
      check("macwr_valid", out_valid, 1);
      check("macwr_data", out_data, exp);
      step();
   endtask

   task automatic mid_reset_test();
      int got;
      bit ok;
      bit seen = 1'b0;
      wait_ready(ok);
      if (!ok) return;
      in_valid = 1'b1; in_ch = 2'd1; in_data = 24'(4444);
      step();
      in_valid = 1'b0;
      repeat (5) step();
      reset = 1'b1;
      coef_we = 1'b1; coef_addr = 4'd0; coef_data = 16'sd999;
      in_valid = 1'b1; in_ch = 2'd0; in_data = 24'(55);
      step();
      check("midrst_in_ready", in_ready, 0);
      check("midrst_out_valid", out_valid, 0);
      reset = 1'b0; coef_we = 1'b0; in_valid = 1'b0;
      #1;
      check("midrst_release_ready", in_ready, 1);
      model_reset();
      for (int i = 0; i < int'(TAPS) + 4; i++) begin
         if (out_valid) seen = 1'b1;
         step();
      end
      check("midrst_no_output", seen, 0);
      send(0, 7, 0, got);
      check("midrst_sample7", got, 7);
   endtask

   initial begin
      int got;
      int prev;
      int ch;
      int data;

      tbl[0] = '{coef0: 16384,  ch: 0, data: 1000,     exp: 1000};
      tbl[1] = '{coef0: 16384,  ch: 2, data: -7,       exp: -7};
      tbl[2] = '{coef0: -16384, ch: 1, data: 5,        exp: -5};
      tbl[3] = '{coef0: 8192,   ch: 0, data: 1001,     exp: 501};
      tbl[4] = '{coef0: 8192,   ch: 1, data: -1001,    exp: -500};
      tbl[5] = '{coef0: 32767,  ch: 0, data: 8388607,  exp: 8388607};
      tbl[6] = '{coef0: 32767,  ch: 2, data: -8388608, exp: -8388608};
      tbl[7] = '{coef0: 16384,  ch: 1, data: 8388607,  exp: 8388607};

      model_reset();
      do_reset(1'b1);

      for (int i = 0; i < 8; i++) begin
         if (i > 0) write_coef(0, tbl[i].coef0);
         send(tbl[i].ch, tbl[i].data, 0, got);
         check("tbl_data", got, tbl[i].exp);
      end

      // Moving average on ch1 and back-to-back throughput
      do_reset(1'b0);
      for (int k = 0; k < int'(TAPS); k++) write_coef(k, 1024);
      prev = 0;
      for (int i = 0; i < 18; i++) begin
         send(1, 16000, 0, got);
         check("avg_data", got, (i < 16) ? (i + 1) * 1000 : 16000);
         if (i > 0) check("period", acc_cyc - prev, TAPS + 2);
         prev = acc_cyc;
      end

      // Backpressure for 10 cycles in HOLD
      send(1, -16000, 10, got);

      // Channel isolation under identity, then averaging, with an invalid channel
      do_reset(1'b0);
      for (int r = 0; r < 3; r++) begin
         send(0, 100, 0, got);  check("iso_ch0", got, 100);
         send(1, -200, 0, got); check("iso_ch1", got, -200);
         send(2, 300, 0, got);  check("iso_ch2", got, 300);
      end
      send_invalid();
      for (int k = 0; k < int'(TAPS); k++) write_coef(k, 1024);
      for (int r = 0; r < 3; r++) begin
         send(0, 100, 0, got);
         send_invalid();
         send(1, -200, 0, got);
         send(2, 300, r, got);
      end

      mac_write_test();
      send(2, -777, 0, got);

      mid_reset_test();

      // Randomized traffic against the model
      for (int k = 0; k < int'(TAPS); k++) write_coef(k, int'($urandom_range(0, 65535)) - 32768);
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) == 0)
            write_coef(int'($urandom_range(0, TAPS - 1)), int'($urandom_range(0, 65535)) - 32768);
         ch = int'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1) data = int'($urandom % 32'd16777216) - 8388608;
         else                           data = int'($urandom_range(0, 2000)) - 1000;
         if (ch == 3) send_invalid();
         else         send(ch, data, int'($urandom_range(0, 2)), got);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
